// File: rtl/pong_pkg.sv
// Shared Pong geometry, centre positions and game state encoding.
package pong_pkg;

  localparam int ACTIVE_WIDTH  = 640;
  localparam int ACTIVE_HEIGHT = 480;
  localparam int PADDLE_WIDTH  = 10;
  localparam int PADDLE_HEIGHT = 50;
  localparam int BALL_SIZE     = 10;
  localparam int PADDLE_SPEED  = 4;
  localparam int BALL_SPEED    = 2;
  localparam int MAX_SPEED     = 6;
  localparam int SERVE_FRAMES  = 60;
  localparam int WIN_SCORE     = 7;

  localparam int BALL_X_MAX   = ACTIVE_WIDTH - PADDLE_WIDTH - BALL_SIZE;
  localparam int BALL_Y_MAX   = ACTIVE_HEIGHT - BALL_SIZE;
  localparam int PADDLE_Y_MAX = ACTIVE_HEIGHT - PADDLE_HEIGHT;

  localparam logic [9:0] BALL_X_CENTRE   = 10'((ACTIVE_WIDTH - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y_CENTRE   = 10'((ACTIVE_HEIGHT - BALL_SIZE) / 2);
  localparam logic [9:0] PADDLE_Y_CENTRE = 10'((ACTIVE_HEIGHT - PADDLE_HEIGHT) / 2);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} game_state_t;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Frame-rate control inputs and registered object positions of the Pong sequencer.
interface pong_game_ctrl_if;

  logic       frame_tick;
  logic       start;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] paddle1_y;
  logic [9:0] paddle2_y;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       game_over;

  modport master (
    output frame_tick, start, p1_up, p1_down, p2_up, p2_down,
    input  ball_x, ball_y, paddle1_y, paddle2_y, score1, score2, game_over
  );

  modport slave (
    input  frame_tick, start, p1_up, p1_down, p2_up, p2_down,
    output ball_x, ball_y, paddle1_y, paddle2_y, score1, score2, game_over
  );

endinterface

// File: rtl/pong_paddle.sv
// Saturating paddle position, moved once per frame_tick while enabled.
// Registered output, updates the cycle after the tick; opposing buttons cancel.
module pong_paddle
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       up,
  input  logic       down,
  output logic [9:0] y
);

  logic [9:0]  y_q, y_d;
  logic [10:0] y_e;

  assign y_e = {1'b0, y_q};

  always_comb begin
    y_d = y_q;
    if (frame_tick && enable && (up != down)) begin
      if (up) begin
        y_d = (y_e < 11'(PADDLE_SPEED)) ? 10'd0 : y_q - 10'(PADDLE_SPEED);
      end else begin
        y_d = (y_e + 11'(PADDLE_SPEED) > 11'(PADDLE_Y_MAX)) ? 10'(PADDLE_Y_MAX)
                                                            : y_q + 10'(PADDLE_SPEED);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) y_q <= PADDLE_Y_CENTRE;
    else       y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong sequencer: ball, scores and serve/play/over flow, stepped once per frame_tick.
// Outputs registered (one cycle after the tick); PONG_SPEEDUP_EN adds per-hit horizontal speed-up.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  pong_game_ctrl_if.slave        bus
);

  game_state_t state_q, state_d;
  logic [9:0]  bx_q, bx_d, by_q, by_d;
  logic        dx_q, dx_d, dy_q, dy_d;   // 1 = moving towards larger coordinate
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  s1_q, s1_d, s2_q, s2_d;
  logic [9:0]  p1_y, p2_y;
  logic        pad_en;
  logic [9:0]  sx;
  logic [10:0] sx_e, bx_e, by_e, p1_e, p2_e;
  logic        hit1, hit2, lost_left, lost_right;

`ifdef PONG_SPEEDUP_EN
  logic [2:0] spd_q, spd_d;
  assign sx = {7'd0, spd_q};
`else
  assign sx = 10'(BALL_SPEED);
`endif

  assign pad_en = (state_q == SERVE) || (state_q == PLAY);

  pong_paddle u_paddle1 (
    .clk(clk), .reset(reset), .frame_tick(bus.frame_tick), .enable(pad_en),
    .up(bus.p1_up), .down(bus.p1_down), .y(p1_y)
  );

  pong_paddle u_paddle2 (
    .clk(clk), .reset(reset), .frame_tick(bus.frame_tick), .enable(pad_en),
    .up(bus.p2_up), .down(bus.p2_down), .y(p2_y)
  );

  assign sx_e = {1'b0, sx};
  assign bx_e = {1'b0, bx_q};
  assign by_e = {1'b0, by_q};
  assign p1_e = {1'b0, p1_y};
  assign p2_e = {1'b0, p2_y};

  // Collisions see the paddle positions from before this tick's paddle update.
  assign hit1 = (by_e + 11'(BALL_SIZE) > p1_e) && (by_e < p1_e + 11'(PADDLE_HEIGHT));
  assign hit2 = (by_e + 11'(BALL_SIZE) > p2_e) && (by_e < p2_e + 11'(PADDLE_HEIGHT));

  always_comb begin
    state_d    = state_q;
    bx_d       = bx_q;
    by_d       = by_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    cnt_d      = cnt_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    lost_left  = 1'b0;
    lost_right = 1'b0;
`ifdef PONG_SPEEDUP_EN
    spd_d      = spd_q;
`endif
    if (bus.frame_tick) begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = SERVE;
            cnt_d   = '0;
          end
        end
        SERVE: begin
          bx_d  = BALL_X_CENTRE;
          by_d  = BALL_Y_CENTRE;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(SERVE_FRAMES - 2)) state_d = PLAY;
        end
        PLAY: begin
          if (!dy_q && by_e < 11'(BALL_SPEED)) begin
            by_d = '0;
            dy_d = 1'b1;
          end else if (dy_q && by_e + 11'(BALL_SPEED) > 11'(BALL_Y_MAX)) begin
            by_d = 10'(BALL_Y_MAX);
            dy_d = 1'b0;
          end else begin
            by_d = dy_q ? by_q + 10'(BALL_SPEED) : by_q - 10'(BALL_SPEED);
          end

          if (!dx_q && bx_e < 11'(PADDLE_WIDTH) + sx_e) begin
            if (hit1) begin
              bx_d = 10'(PADDLE_WIDTH);
              dx_d = 1'b1;
            end else begin
              lost_left = 1'b1;
            end
          end else if (dx_q && bx_e + sx_e > 11'(BALL_X_MAX)) begin
            if (hit2) begin
              bx_d = 10'(BALL_X_MAX);
              dx_d = 1'b0;
            end else begin
              lost_right = 1'b1;
            end
          end else begin
            bx_d = dx_q ? bx_q + sx : bx_q - sx;
          end

`ifdef PONG_SPEEDUP_EN
          if ((dx_q != dx_d) && (spd_q != 3'(MAX_SPEED))) spd_d = spd_q + 3'd1;
`endif

          if (lost_left || lost_right) begin
            bx_d    = BALL_X_CENTRE;
            by_d    = BALL_Y_CENTRE;
            dx_d    = lost_right;
            cnt_d   = '0;
            state_d = SERVE;
            if (lost_left) begin
              s2_d = s2_q + 4'd1;
              if (s2_d == 4'(WIN_SCORE)) state_d = OVER;
            end else begin
              s1_d = s1_q + 4'd1;
              if (s1_d == 4'(WIN_SCORE)) state_d = OVER;
            end
          end
        end
        OVER: begin
          if (bus.start) begin
            s1_d    = '0;
            s2_d    = '0;
            cnt_d   = '0;
            state_d = SERVE;
          end
        end
        default: state_d = IDLE;
      endcase
`ifdef PONG_SPEEDUP_EN
      if (state_d == SERVE) spd_d = 3'(BALL_SPEED);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bx_q    <= BALL_X_CENTRE;
      by_q    <= BALL_Y_CENTRE;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

`ifdef PONG_SPEEDUP_EN
  always_ff @(posedge clk) begin
    if (reset) spd_q <= 3'(BALL_SPEED);
    else       spd_q <= spd_d;
  end
`endif

  assign bus.ball_x    = bx_q;
  assign bus.ball_y    = by_q;
  assign bus.paddle1_y = p1_y;
  assign bus.paddle2_y = p2_y;
  assign bus.score1    = s1_q;
  assign bus.score2    = s2_q;
  assign bus.game_over = (state_q == OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed game trajectory for pong_game_ctrl; expectations queued at stimulus, checked by a monitor.
module tb_pong_game_ctrl;

  typedef struct packed {
    logic [9:0] bx;
    logic [9:0] by;
    logic [9:0] p1;
    logic [9:0] p2;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       go;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic chk_arm = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t  exp_q[$];
  string name_q[$];

  pong_game_ctrl_if bus ();

  pong_game_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_now(input string nm, input int bx, input int by, input int p1,
                            input int p2, input int s1, input int s2, input int go);
    exp_t e;
    e.bx = 10'(bx); e.by = 10'(by); e.p1 = 10'(p1); e.p2 = 10'(p2);
    e.s1 = 4'(s1);  e.s2 = 4'(s2);  e.go = 1'(go);
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_arm = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic tick_chk(input string nm, input int bx, input int by, input int p1,
                          input int p2, input int s1, input int s2, input int go);
    @(negedge clk);
    bus.frame_tick = 1'b1;
    expect_now(nm, bx, by, p1, p2, s1, s2, go);
    @(negedge clk);
    bus.frame_tick = 1'b0;
    chk_arm = 1'b0;
  endtask

  task automatic reset_chk(input string nm);
    @(negedge clk);
    reset = 1'b1;
    expect_now(nm, 315, 235, 215, 215, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    chk_arm = 1'b0;
  endtask

  // Monitor: compares registered outputs just after each armed clock edge.
  initial begin
    exp_t  act, e;
    string nm;
    forever begin
      @(posedge clk);
      if (chk_arm) begin
        #1;
        act.bx = bus.ball_x;    act.by = bus.ball_y;
        act.p1 = bus.paddle1_y; act.p2 = bus.paddle2_y;
        act.s1 = bus.score1;    act.s2 = bus.score2;
        act.go = bus.game_over;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got ball=(%0d,%0d) pad=(%0d,%0d) score=(%0d,%0d) over=%0d, expected ball=(%0d,%0d) pad=(%0d,%0d) score=(%0d,%0d) over=%0d",
                   nm, act.bx, act.by, act.p1, act.p2, act.s1, act.s2, act.go,
                   e.bx, e.by, e.p1, e.p2, e.s1, e.s2, e.go);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.p1_up      = 1'b0;
    bus.p1_down    = 1'b0;
    bus.p2_up      = 1'b0;
    bus.p2_down    = 1'b0;
    repeat (2) @(negedge clk);
    reset_chk("reset");

    // IDLE ignores buttons; start enters SERVE
    bus.p1_up = 1'b1;
    tick_chk("idle_frozen", 315, 235, 215, 215, 0, 0, 0);
    bus.p1_up = 1'b0;
    bus.start = 1'b1;
    tick_chk("start",       315, 235, 215, 215, 0, 0, 0);
    bus.start = 1'b0;

    // Paddle motion and saturation during SERVE
    bus.p1_up = 1'b1; bus.p2_down = 1'b1;
    tick_chk("pad_step",    315, 235, 211, 219, 0, 0, 0);
    run(39);
    bus.p2_up = 1'b1;
    tick_chk("pad_both",    315, 235, 51, 375, 0, 0, 0);
    bus.p2_up = 1'b0; bus.p2_down = 1'b0;
    run(12);
    tick_chk("pad_sat",     315, 235, 0, 375, 0, 0, 0);
    run(4);
    tick_chk("serve_end",   315, 235, 0, 375, 0, 0, 0);
    tick_chk("launch",      317, 237, 0, 375, 0, 0, 0);
    bus.p1_up = 1'b0;

    // Point 1: bottom wall, then right paddle hit
    bus.p1_down = 1'b1;
    run(49);
    tick_chk("p1_down",     417, 337, 200, 375, 0, 0, 0);
    bus.p1_down = 1'b0;
    run(100);
    tick_chk("right_pre",   619, 402, 200, 375, 0, 0, 0);
    tick_chk("right_hit",   620, 400, 200, 375, 0, 0, 0);

    // Top wall on even y, then left paddle hit
    run(304);
    tick_chk("left_pre",    10, 208, 200, 375, 0, 0, 0);
    tick_chk("left_hit",    10, 210, 200, 375, 0, 0, 0);

    // Right miss
    run(304);
    tick_chk("right_pre2",  620, 122, 200, 375, 0, 0, 0);
    tick_chk("right_miss",  315, 235, 200, 375, 1, 0, 0);

    // Point 3: served upward, odd y meets the top wall
    run(175);
    tick_chk("top_pre",     549, 1, 200, 375, 1, 0, 0);
    tick_chk("top_wall",    551, 0, 200, 375, 1, 0, 0);
    tick_chk("top_after",   553, 2, 200, 375, 1, 0, 0);
    run(33);
    tick_chk("miss2",       315, 235, 200, 375, 2, 0, 0);

    // Move right paddle back to centre, then right keeps missing
    bus.p2_up = 1'b1;
    run(40);
    bus.p2_up = 1'b0;
    run(171);
    tick_chk("miss3",       315, 235, 200, 215, 3, 0, 0);
    for (int s = 4; s <= 7; s++) begin
      run(211);
      tick_chk($sformatf("miss%0d", s), 315, 235, 200, 215, s, 0, (s == 7) ? 1 : 0);
    end

    // OVER: frozen until start, which clears scores
    bus.p1_up = 1'b1;
    tick_chk("over_frozen", 315, 235, 200, 215, 7, 0, 1);
    bus.p1_up = 1'b0;
    bus.start = 1'b1;
    tick_chk("restart",     315, 235, 200, 215, 0, 0, 0);
    bus.start = 1'b0;
    run(10);
    reset_chk("reset_mid");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game sequencer for Pong: owns ball and paddle positions plus scores, and feeds the pixel-drawing stage.
- Advances the game once per video frame on frame_tick; all outputs are registered.
- Sits between the player button inputs / VGA timing generator and the object renderer.

Parameters:
ACTIVE_WIDTH, 640, visible pixels per line
ACTIVE_HEIGHT, 480, visible lines
PADDLE_WIDTH, 10, paddle width in pixels
PADDLE_HEIGHT, 50, paddle height in pixels
BALL_SIZE, 10, ball width and height in pixels
PADDLE_SPEED, 4, paddle pixels per frame
BALL_SPEED, 2, ball pixels per frame on each axis
SERVE_FRAMES, 60, frames the ball rests at centre before launch
WIN_SCORE, 7, points that end the game

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse at the start of vertical blank
start  in  1  level; begins or restarts the game
p1_up, p1_down, p2_up, p2_down  in  1 each  paddle buttons, already synchronised
ball_x, ball_y  out  10  ball top-left corner
paddle1_y, paddle2_y  out  10  paddle top edges; left paddle at x=0, right paddle at x=ACTIVE_WIDTH-PADDLE_WIDTH
score1, score2  out  4  points won by player 1 and player 2
game_over  out  1  high while in state OVER

Behaviour:
- Reset values:
  - ball at (315,235); paddles at 215; scores 0; game_over 0.
  - Direction dx=+1, dy=+1; serve counter 0; state IDLE.
- State machine: IDLE, SERVE, PLAY, OVER. Every transition and position update occurs only in a cycle where frame_tick=1. Outputs change in the cycle after that tick. Nothing changes between ticks.
- IDLE: start=1 -> SERVE with the counter cleared.
- SERVE:
  - Ball held at centre; counter increments each tick.
  - When the counter reaches SERVE_FRAMES-1 -> PLAY.
- PLAY, per tick:
  - Compute the next ball position as position ± speed.
  - Collisions use the paddle positions from before this tick's update.
- Top/bottom walls:
  - If dy<0 and ball_y<speed: ball_y=0, dy=+1.
  - If dy>0 and ball_y+speed > ACTIVE_HEIGHT-BALL_SIZE: ball_y=470, dy=-1.
- Left side (dx<0, ball_x<PADDLE_WIDTH+speed):
  - Hit when ball_y+BALL_SIZE>paddle1_y and ball_y<paddle1_y+PADDLE_HEIGHT. Then ball_x=PADDLE_WIDTH, dx=+1.
  - Otherwise it is a miss: score2+1.
- Right side: mirror of the left side, using paddle2_y and ball_x clamped to 620. A miss gives score1+1.
- A wall and a paddle event in the same tick: apply both (corner bounce).
- After a miss:
  - Ball goes to centre; dx points toward the player who conceded.
  - If the new score equals WIN_SCORE -> OVER, else -> SERVE.
- OVER: ball frozen at centre; game_over=1. start=1 -> clear both scores, then SERVE.
- Paddles:
  - Move in SERVE and PLAY only; frozen in IDLE and OVER.
  - up (decreasing y) / down by PADDLE_SPEED.
  - up and down both pressed: no move.
  - Saturate at 0 and at ACTIVE_HEIGHT-PADDLE_HEIGHT (430). No wrap-around.
- Arithmetic: use 11-bit intermediates for all comparisons so that underflow never wraps.
- Reset asserted mid-game: all registers return to their reset values in the next cycle, regardless of frame_tick.

Optional Feature:
- Macro PONG_SPEEDUP_EN.
- Defined:
  - Each paddle hit increases the horizontal speed by 1, saturating at 6.
  - The speed returns to BALL_SPEED on every serve.
  - The vertical speed is unchanged.
- Undefined: horizontal speed is the constant BALL_SPEED; the speed register is absent.

Decomposition:
- Package pong_pkg holds:
  - geometry constants (ACTIVE_*, PADDLE_*, BALL_SIZE);
  - centre-position constants;
  - the game_state_t enum {IDLE, SERVE, PLAY, OVER}.
- Sub-module pong_paddle, instanced twice:
  - inputs: clk, reset, frame_tick, enable, up, down;
  - output: y;
  - contains the saturating paddle motion.
- The ball and score logic stays in pong_game_ctrl.

Test Plan:
- Reset, then start=1 plus 60 ticks -> ball stays at (315,235) through SERVE; after the 61st tick ball=(317,237).
- Hold p1_up for 60 ticks from 215 -> paddle1_y goes 211, 207, …, then holds at 0. Press up and down together -> value unchanged.
- Ball with dy=-1 at ball_y=1 -> next tick ball_y=0, dy=+1, the following tick ball_y=2.
- Ball at x=11, dx=-1, paddle1_y=200, ball_y=220 -> ball_x=10, dx=+1, no score change.
- Same setup with paddle1_y=0 -> score2=1, ball to centre, state SERVE, dx=-1.
- Score1=6 and the right-side ball misses -> score1=7, game_over=1. Then start -> scores 0, SERVE. With PONG_SPEEDUP_EN, after 3 hits ball_x steps by 5.
